countdown_timer_8bit: RTL and testbench

//   Loadable down-counter/timer: the decrementing counterpart of the 8-bit enabled up-counter.

---
 rtl/countdown_timer_8bit.sv | 95 +++++++++
 tb/tb_countdown_timer_8bit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_8bit.sv
// Loadable down-counter/timer with terminal-count pulse, one-shot or auto-reload mode.
// Ports:
//   clk        - clock, all state changes on rising edge
//   reset      - asynchronous active-low reset
//   load       - synchronous load strobe, captures load_val as start and reload value
//   load_val   - start/reload value
//   count_enb  - decrement enable, one step per enabled cycle while running
//   stop       - synchronous abort, returns to IDLE holding the count
//   count      - current counter value (registered)
//   tc         - one-cycle terminal-count pulse (registered)
//   busy       - high while running (registered)
//   done       - sticky one-shot completion flag (registered)
module countdown_timer_8bit #(
    parameter int unsigned WIDTH       = 8,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_enb,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_n;
    logic [WIDTH-1:0] count_n;
    logic             tc_n;
    logic             done_n;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            tc         <= tc_n;
            busy       <= (state_n == ST_RUN);
            done       <= done_n;
        end
    end

    // Next-state and next-output logic; priority load > stop > count_enb
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        done_n   = done;

        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            done_n   = 1'b0;
            state_n  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (stop) begin
            done_n  = 1'b0;
            state_n = ST_IDLE;
        end else if ((state == ST_RUN) && count_enb) begin
            if (count > WIDTH'(1)) begin
                count_n = count - WIDTH'(1);
            end else begin
                // Terminal step; count==0 cannot occur in RUN but is treated the same way
                tc_n = 1'b1;
                if (AUTO_RELOAD) begin
                    count_n = reload_reg;
                end else begin
                    count_n = '0;
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// Self-checking bench: one-shot and auto-reload instances, queue-based scoreboard.
module tb_countdown_timer_8bit;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk;
    logic       reset;

    logic       os_load;
    logic [7:0] os_load_val;
    logic       os_enb;
    logic       os_stop;
    logic [7:0] os_count;
    logic       os_tc;
    logic       os_busy;
    logic       os_done;

    logic       ar_load;
    logic [7:0] ar_load_val;
    logic       ar_enb;
    logic       ar_stop;
    logic [7:0] ar_count;
    logic       ar_tc;
    logic       ar_busy;
    logic       ar_done;

    int checks = 0;
    int errors = 0;
    int ar_tc_pulses = 0;

    exp_t q_os[$];
    exp_t q_ar[$];
    exp_t mon_os;
    exp_t mon_ar;

    countdown_timer_8bit #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut_os (
        .clk       (clk),
        .reset     (reset),
        .load      (os_load),
        .load_val  (os_load_val),
        .count_enb (os_enb),
        .stop      (os_stop),
        .count     (os_count),
        .tc        (os_tc),
        .busy      (os_busy),
        .done      (os_done)
    );

    countdown_timer_8bit #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk       (clk),
        .reset     (reset),
        .load      (ar_load),
        .load_val  (ar_load_val),
        .count_enb (ar_enb),
        .stop      (ar_stop),
        .count     (ar_count),
        .tc        (ar_tc),
        .busy      (ar_busy),
        .done      (ar_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: each entry pushed before an edge is checked just after it
    always @(posedge clk) begin
        #1;
        if (q_os.size() > 0) begin
            mon_os = q_os.pop_front();
            checks++;
            if ({os_count, os_tc, os_busy, os_done} !== mon_os) begin
                errors++;
                $display("FAIL oneshot t=%0t got count=%0d tc=%b busy=%b done=%b want count=%0d tc=%b busy=%b done=%b",
                         $time, os_count, os_tc, os_busy, os_done,
                         mon_os.count, mon_os.tc, mon_os.busy, mon_os.done);
            end
        end
        if (q_ar.size() > 0) begin
            mon_ar = q_ar.pop_front();
            checks++;
            if (ar_tc === 1'b1) ar_tc_pulses++;
            if ({ar_count, ar_tc, ar_busy, ar_done} !== mon_ar) begin
                errors++;
                $display("FAIL autoreload t=%0t got count=%0d tc=%b busy=%b done=%b want count=%0d tc=%b busy=%b done=%b",
                         $time, ar_count, ar_tc, ar_busy, ar_done,
                         mon_ar.count, mon_ar.tc, mon_ar.busy, mon_ar.done);
            end
        end
    end

    task automatic drive_os(input logic l, input logic [7:0] lv, input logic e, input logic s,
                            input logic [7:0] xc, input logic xtc, input logic xb, input logic xd);
        @(negedge clk);
        os_load = l; os_load_val = lv; os_enb = e; os_stop = s;
        q_os.push_back('{count: xc, tc: xtc, busy: xb, done: xd});
    endtask

    task automatic drive_ar(input logic l, input logic [7:0] lv, input logic e, input logic s,
                            input logic [7:0] xc, input logic xtc, input logic xb, input logic xd);
        @(negedge clk);
        ar_load = l; ar_load_val = lv; ar_enb = e; ar_stop = s;
        q_ar.push_back('{count: xc, tc: xtc, busy: xb, done: xd});
    endtask

    task automatic drain();
        @(negedge clk);
        os_load = 1'b0; os_enb = 1'b0; os_stop = 1'b0;
        ar_load = 1'b0; ar_enb = 1'b0; ar_stop = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        os_load = 1'b0; os_load_val = '0; os_enb = 1'b0; os_stop = 1'b0;
        ar_load = 1'b0; ar_load_val = '0; ar_enb = 1'b0; ar_stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({os_count, os_tc, os_busy, os_done} !== 11'h000) begin
            errors++;
            $display("FAIL reset_oneshot got %h want 000", {os_count, os_tc, os_busy, os_done});
        end
        checks++;
        if ({ar_count, ar_tc, ar_busy, ar_done} !== 11'h000) begin
            errors++;
            $display("FAIL reset_autoreload got %h want 000", {ar_count, ar_tc, ar_busy, ar_done});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle_enable();
        for (int i = 0; i < 10; i++) drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_oneshot();
        drive_os(1'b1, 8'd5, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0);
        for (int c = 4; c >= 1; c--) drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'(c), 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_autoreload();
        ar_tc_pulses = 0;
        drive_ar(1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            case (i % 3)
                1: drive_ar(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
                2: drive_ar(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
                default: drive_ar(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0);
            endcase
        end
        drive_ar(1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (ar_tc_pulses !== 4) begin
            errors++;
            $display("FAIL autoreload_tc_count got %0d want 4", ar_tc_pulses);
        end
    endtask

    task automatic test_gated_enable();
        drive_os(1'b1, 8'd4, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        drive_os(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_priority();
        drive_os(1'b1, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        // load on the terminal step: load wins, no tc
        drive_os(1'b1, 8'd7, 1'b1, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd6, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        // stop beats enable
        drive_os(1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        drive_os(1'b1, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        drive_os(1'b1, 8'd2, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_zero_load_and_reset();
        drive_os(1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive_os(1'b1, 8'hC8, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0);
        drive_ar(1'b1, 8'd9, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1, 1'b0);
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'hC7, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        os_enb = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({os_count, os_tc, os_busy, os_done} !== 11'h000) begin
            errors++;
            $display("FAIL async_reset_oneshot got %h want 000", {os_count, os_tc, os_busy, os_done});
        end
        checks++;
        if ({ar_count, ar_tc, ar_busy, ar_done} !== 11'h000) begin
            errors++;
            $display("FAIL async_reset_autoreload got %h want 000", {ar_count, ar_tc, ar_busy, ar_done});
        end
        @(negedge clk);
        os_enb = 1'b0;
        reset = 1'b1;
        drive_os(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_idle_enable();
        test_oneshot();
        test_autoreload();
        test_gated_enable();
        test_priority();
        test_back_to_back();
        test_zero_load_and_reset();
        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
